pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline-stage buffer, the next generation of our fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds up to DEPTH packed stage bundles of WIDTH bits in a circular buffer and replaces the ad-hoc writeEN/flush latch with a valid/ready handshake and synchronous flush. This lets a stalled downstream stage absorb in-flight instructions without a combinational stall path back to the fetch stage. It sits between any two pipeline stages. Callers pack their control and data fields into `in_data`.

---
 rtl/pipe_stage_buf.sv | 54 +++++
 tb/tb_pipe_stage_buf.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready circular buffer between pipeline stages, with synchronous flush.
module pipe_stage_buf #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 2,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    assign in_ready  = count_q != CW'(DEPTH);
    assign out_valid = count_q != '0;
    assign out_data  = mem_q[rp_q];
    assign count     = count_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    always_comb begin
        wp_d    = push ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d    = pop ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1) : rp_q;
        count_d = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            if (CLEAR_ON_FLUSH)
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            if (push) mem_q[wp_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf at DEPTH=2 and a DEPTH=3 wrap-around run.
module tb_pipe_stage_buf;
    logic        clk = 1'b0;
    logic        nrst;
    logic        f2, iv2, ordy2, ir2, ov2;
    logic [31:0] id2, od2;
    logic [1:0]  c2;
    logic        f3, iv3, ordy3, ir3, ov3;
    logic [31:0] id3, od3;
    logic [1:0]  c3;
    int          checks = 0;
    int          failures = 0;
    logic        pend_q = 1'b0;
    logic [31:0] pd_q;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .CLEAR_ON_FLUSH(1'b1)) u2 (
        .CLK(clk), .nRST(nrst), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .count(c2));

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .CLEAR_ON_FLUSH(1'b1)) u3 (
        .CLK(clk), .nRST(nrst), .flush(f3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .count(c3));

    always @(posedge clk) begin
        if (pend_q) assert (iv2 && id2 == pd_q) else $error("protocol: held bundle dropped or changed");
        pend_q <= nrst & iv2 & ~ir2 & ~f2;
        pd_q   <= id2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        int sent, rcvd, cyc;
        logic push, pop;
        nrst = 1'b0;
        {f2, iv2, ordy2, f3, iv3, ordy3} = '0;
        id2 = '0;
        id3 = '0;
        #3;
        chk("rst_count", 32'(c2), 0);
        chk("rst_in_ready", 32'(ir2), 1);
        chk("rst_out_valid", 32'(ov2), 0);
        chk("rst_out_data", od2, 0);
        tick();
        tick();
        nrst = 1'b1;
        iv2 = 1; id2 = 32'hAAAA0001;
        tick();
        chk("fill1_count", 32'(c2), 1);
        chk("fill1_data", od2, 32'hAAAA0001);
        chk("fill1_ready", 32'(ir2), 1);
        id2 = 32'hAAAA0002;
        tick();
        chk("fill2_count", 32'(c2), 2);
        chk("fill2_ready", 32'(ir2), 0);
        id2 = 32'hAAAA0003;
        tick();
        chk("held_count", 32'(c2), 2);
        chk("held_data", od2, 32'hAAAA0001);
        ordy2 = 1;
        tick();
        chk("drain1_data", od2, 32'hAAAA0002);
        chk("drain1_count", 32'(c2), 1);
        tick();
        chk("drain2_data", od2, 32'hAAAA0003);
        chk("drain2_count", 32'(c2), 1);
        iv2 = 0;
        tick();
        chk("drain3_count", 32'(c2), 0);
        chk("drain3_valid", 32'(ov2), 0);
        ordy2 = 0; iv2 = 1; id2 = 32'hBBBB0001;
        tick();
        id2 = 32'hBBBB0002;
        tick();
        id2 = 32'hBBBB0003; ordy2 = 1;
        chk("fullpop_ready", 32'(ir2), 0);
        tick();
        chk("fullpop_count", 32'(c2), 1);
        chk("fullpop_data", od2, 32'hBBBB0002);
        ordy2 = 0;
        tick();
        chk("fullpop_refill", 32'(c2), 2);
        chk("fullpop_head", od2, 32'hBBBB0002);
        f2 = 1; id2 = 32'h0000DEAD; ordy2 = 1;
        tick();
        chk("flush_count", 32'(c2), 0);
        chk("flush_valid", 32'(ov2), 0);
        chk("flush_data", od2, 0);
        tick();
        chk("flush_hold_count", 32'(c2), 0);
        chk("flush_hold_ready", 32'(ir2), 1);
        f2 = 0; id2 = 32'h00001234; ordy2 = 0;
        tick();
        chk("post_flush_data", od2, 32'h00001234);
        chk("post_flush_count", 32'(c2), 1);
        iv2 = 0; ordy2 = 1;
        tick();
        chk("post_flush_empty", 32'(c2), 0);
        iv2 = 1;
        for (int i = 0; i < 16; i++) begin
            id2 = 32'h100 + 32'(i);
            tick();
            chk("stream_data", od2, 32'h100 + 32'(i));
            chk("stream_count", 32'(c2), 1);
        end
        iv2 = 0;
        tick();
        chk("stream_end", 32'(c2), 0);
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 10 && cyc < 200) begin
            iv3 = sent < 10;
            id3 = 32'h300 + 32'(sent);
            ordy3 = 1'($urandom_range(0, 1));
            push = iv3 && ir3;
            pop = ov3 && ordy3;
            chk("wrap_count", 32'(c3), 32'(q.size()));
            if (pop) begin
                chk("wrap_data", od3, q[0]);
                void'(q.pop_front());
                rcvd++;
            end
            tick();
            if (push) begin
                q.push_back(id3);
                sent++;
            end
            cyc++;
        end
        chk("wrap_received", 32'(rcvd), 10);
        iv3 = 0; ordy3 = 0;
        ordy2 = 0; iv2 = 1; id2 = 32'hC0000001;
        tick();
        id2 = 32'hC0000002;
        tick();
        iv2 = 0;
        chk("pre_reset_count", 32'(c2), 2);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_count", 32'(c2), 0);
        chk("midrst_valid", 32'(ov2), 0);
        chk("midrst_ready", 32'(ir2), 1);
        chk("midrst_data", od2, 0);
        tick();
        nrst = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
